// File: rtl/data_cache.sv
// Direct-mapped, write-back, write-allocate byte cache in front of a 4-byte-block data memory.
// Define DATA_CACHE_STATS_EN to add the hit_count / miss_count ports.
module data_cache #(
  parameter int unsigned INDEX_BITS  = 3,
  parameter int unsigned OFFSET_BITS = 2
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        READ,
  input  logic        WRITE,
  input  logic [7:0]  ADDRESS,
  input  logic [7:0]  WRITEDATA,
  output logic [7:0]  READDATA,
  output logic        BUSYWAIT,
  output logic        mem_read,
  output logic        mem_write,
  output logic [5:0]  mem_address,
  output logic [31:0] mem_writedata,
  input  logic [31:0] mem_readdata,
  input  logic        mem_busywait
`ifdef DATA_CACHE_STATS_EN
  ,
  output logic [15:0] hit_count,
  output logic [15:0] miss_count
`endif
);

  localparam int unsigned TAG_W = 6 - INDEX_BITS;
  localparam int unsigned LINES = 1 << INDEX_BITS;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WRITEBACK = 2'd1,
    S_FETCH     = 2'd2,
    S_UPDATE    = 2'd3
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [LINES-1:0] r_valid;
  logic [LINES-1:0] r_dirty;
  logic [TAG_W-1:0] r_tag  [LINES];
  logic [31:0]      r_data [LINES];
  logic [31:0]      r_fill;
  logic [TAG_W-1:0] r_req_tag;
  logic [INDEX_BITS-1:0] r_req_index;

  logic [TAG_W-1:0]       w_tag;
  logic [INDEX_BITS-1:0]  w_index;
  logic [OFFSET_BITS-1:0] w_offset;
  logic                   w_req;
  logic                   w_hit;
  logic                   w_wr_hit;
  logic                   w_xfer_done;
  logic [TAG_W-1:0]       w_cur_tag;
  logic [INDEX_BITS-1:0]  w_cur_index;
  logic                   w_mem_read;
  logic                   w_mem_write;
  logic [5:0]             w_mem_address;
  logic [31:0]            w_mem_writedata;

  assign w_tag       = ADDRESS[7 -: TAG_W];
  assign w_index     = ADDRESS[OFFSET_BITS +: INDEX_BITS];
  assign w_offset    = ADDRESS[OFFSET_BITS-1:0];
  assign w_req       = READ | WRITE;
  assign w_hit       = r_valid[w_index] && (r_tag[w_index] == w_tag);
  assign w_wr_hit    = (r_state == S_IDLE) && WRITE && w_hit;
  assign w_xfer_done = !mem_busywait;

  // The request is latched while idle so a miss keeps using the address that caused it
  assign w_cur_tag   = (r_state == S_IDLE) ? w_tag   : r_req_tag;
  assign w_cur_index = (r_state == S_IDLE) ? w_index : r_req_index;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_req && !w_hit) begin
          w_next = (r_valid[w_index] && r_dirty[w_index]) ? S_WRITEBACK : S_FETCH;
        end
      end
      S_WRITEBACK: begin
        if (w_xfer_done) w_next = w_req ? S_FETCH : S_IDLE;
      end
      S_FETCH: begin
        if (w_xfer_done) w_next = w_req ? S_UPDATE : S_IDLE;
      end
      S_UPDATE: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Memory-side values are decoded from the next state and then registered
  always_comb begin
    w_mem_read      = 1'b0;
    w_mem_write     = 1'b0;
    w_mem_address   = '0;
    w_mem_writedata = '0;
    BUSYWAIT        = 1'b1;
    READDATA        = '0;
    case (w_next)
      S_WRITEBACK: begin
        w_mem_write     = 1'b1;
        w_mem_address   = {r_tag[w_cur_index], w_cur_index};
        w_mem_writedata = r_data[w_cur_index];
      end
      S_FETCH: begin
        w_mem_read    = 1'b1;
        w_mem_address = {w_cur_tag, w_cur_index};
      end
      default: ;
    endcase
    if (r_state == S_IDLE) begin
      BUSYWAIT = w_req && !w_hit;
      if (w_hit) READDATA = r_data[w_index][{w_offset, 3'b000} +: 8];
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      mem_read      <= 1'b0;
      mem_write     <= 1'b0;
      mem_address   <= '0;
      mem_writedata <= '0;
    end else begin
      mem_read      <= w_mem_read;
      mem_write     <= w_mem_write;
      mem_address   <= w_mem_address;
      mem_writedata <= w_mem_writedata;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_valid <= '0;
      r_dirty <= '0;
    end else if (r_state == S_UPDATE) begin
      r_valid[r_req_index] <= 1'b1;
      r_dirty[r_req_index] <= 1'b0;
    end else if (w_wr_hit) begin
      r_dirty[w_index] <= 1'b1;
    end
  end

  // Line contents are never cleared; a reset mid-miss leaves the line untouched
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      if (r_state == S_IDLE) begin
        r_req_tag   <= w_tag;
        r_req_index <= w_index;
      end
      if (r_state == S_FETCH && w_xfer_done) r_fill <= mem_readdata;
      if (r_state == S_UPDATE) begin
        r_tag[r_req_index]  <= r_req_tag;
        r_data[r_req_index] <= r_fill;
      end else if (w_wr_hit) begin
        r_data[w_index][{w_offset, 3'b000} +: 8] <= WRITEDATA;
      end
    end
  end

`ifdef DATA_CACHE_STATS_EN
  logic r_from_update;

  // The IDLE cycle right after a fill is a re-evaluation, not a new request
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_from_update <= 1'b0;
      hit_count     <= '0;
      miss_count    <= '0;
    end else begin
      r_from_update <= (r_state == S_UPDATE);
      if (r_state == S_IDLE && w_req && w_hit && !r_from_update && hit_count != 16'hFFFF) begin
        hit_count <= hit_count + 16'd1;
      end
      if (r_state == S_IDLE && w_next != S_IDLE && miss_count != 16'hFFFF) begin
        miss_count <= miss_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_data_cache.sv
// Scoreboard bench for data_cache: expected CPU responses and memory requests are queued
// by the stimulus and checked in order by a negedge monitor.
module tb_data_cache;

  localparam int LAT = 3;
  localparam logic [1:0] K_RD  = 2'd0;
  localparam logic [1:0] K_WR  = 2'd1;
  localparam logic [1:0] K_MWR = 2'd2;
  localparam logic [1:0] K_MRD = 2'd3;

  typedef struct packed {
    logic [1:0]  kind;
    logic [5:0]  addr;
    logic [31:0] data;
  } exp_t;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        READ;
  logic        WRITE;
  logic [7:0]  ADDRESS;
  logic [7:0]  WRITEDATA;
  logic [7:0]  READDATA;
  logic        BUSYWAIT;
  logic        mem_read;
  logic        mem_write;
  logic [5:0]  mem_address;
  logic [31:0] mem_writedata;
  logic [31:0] mem_readdata;
  logic        mem_busywait;
`ifdef DATA_CACHE_STATS_EN
  logic [15:0] hit_count;
  logic [15:0] miss_count;
`endif

  logic [31:0] mem [64];
  int          mem_cnt;
  logic        mem_hold;
  logic        mem_load;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  logic prev_mr  = 1'b0;
  logic prev_mw  = 1'b0;

  always #5 CLK = ~CLK;

  data_cache dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .READ         (READ),
    .WRITE        (WRITE),
    .ADDRESS      (ADDRESS),
    .WRITEDATA    (WRITEDATA),
    .READDATA     (READDATA),
    .BUSYWAIT     (BUSYWAIT),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_address  (mem_address),
    .mem_writedata(mem_writedata),
    .mem_readdata (mem_readdata),
    .mem_busywait (mem_busywait)
`ifdef DATA_CACHE_STATS_EN
    ,
    .hit_count    (hit_count),
    .miss_count   (miss_count)
`endif
  );

  // Block memory: each transfer takes LAT cycles unless mem_hold stretches it
  assign mem_busywait = mem_hold | ((mem_read | mem_write) && (mem_cnt < LAT - 1));
  assign mem_readdata = mem[mem_address];

  always @(posedge CLK) begin
    if (mem_load) begin
      for (int i = 0; i < 64; i++) begin
        mem[i] <= (i == 0) ? 32'hDDCCBBAA : ((i == 8) ? 32'h44332211 : 32'h0);
      end
      mem_cnt <= 0;
    end else if ((mem_read | mem_write) && !mem_busywait) begin
      if (mem_write) mem[mem_address] <= mem_writedata;
      mem_cnt <= 0;
    end else if (mem_read | mem_write) begin
      mem_cnt <= mem_cnt + 1;
    end else begin
      mem_cnt <= 0;
    end
  end

  function automatic void check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endfunction

  function automatic void push(input logic [1:0] kind, input logic [5:0] addr, input logic [31:0] data);
    exp_t e;
    e.kind = kind;
    e.addr = addr;
    e.data = data;
    exp_q.push_back(e);
  endfunction

  function automatic void pop_check(input string name, input logic [1:0] kind,
                                    input logic [5:0] addr, input logic [31:0] data);
    exp_t e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL unexpected %s: got kind %0d addr %h data %h, expected nothing", name, kind, addr, data);
      return;
    end
    e = exp_q.pop_front();
    check({name, " kind"}, 32'(kind), 32'(e.kind));
    if (kind == K_MWR || kind == K_MRD) check({name, " addr"}, 32'(addr), 32'(e.addr));
    if (kind != K_WR && kind != K_MRD) check({name, " data"}, data, e.data);
  endfunction

  always @(negedge CLK) begin
    if (!RESET) begin
      if (mem_write && !prev_mw) pop_check("mem_write", K_MWR, mem_address, mem_writedata);
      if (mem_read && !prev_mr)  pop_check("mem_read", K_MRD, mem_address, 32'h0);
      if ((READ | WRITE) && !BUSYWAIT) begin
        if (WRITE) pop_check("cpu_write", K_WR, 6'h0, 32'h0);
        else       pop_check("cpu_read", K_RD, 6'h0, {24'h0, READDATA});
      end
    end
    prev_mr = mem_read;
    prev_mw = mem_write;
  end

  task automatic cpu_op(input logic rd, input logic wr, input logic [7:0] addr,
                        input logic [7:0] wdata, output int busy);
    bit done;
    READ      = rd;
    WRITE     = wr;
    ADDRESS   = addr;
    WRITEDATA = wdata;
    busy      = 0;
    done      = 1'b0;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge CLK);
      if (!BUSYWAIT) done = 1'b1;
      else           busy++;
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL cpu_op timeout: addr %h still busy after %0d cycles", addr, busy);
    end
    @(posedge CLK);
    #1;
    READ  = 1'b0;
    WRITE = 1'b0;
  endtask

  initial begin
    int  busy;
    bit  seen;
    RESET     = 1'b1;
    mem_load  = 1'b1;
    mem_hold  = 1'b0;
    READ      = 1'b0;
    WRITE     = 1'b0;
    ADDRESS   = 8'h00;
    WRITEDATA = 8'h00;
    repeat (3) @(posedge CLK);
    #1;
    mem_load = 1'b0;
    check("reset BUSYWAIT", 32'(BUSYWAIT), 32'h0);
    check("reset mem_read", 32'(mem_read), 32'h0);
    check("reset mem_write", 32'(mem_write), 32'h0);
    check("reset mem_address", 32'(mem_address), 32'h0);
    check("reset mem_writedata", mem_writedata, 32'h0);
    check("reset READDATA", 32'(READDATA), 32'h0);
    RESET = 1'b0;
    @(posedge CLK);
    #1;

    // Cold miss on block 0: IDLE, 3 FETCH cycles, UPDATE, then the hit
    push(K_MRD, 6'h00, 32'h0);
    push(K_RD, 6'h00, 32'h000000AA);
    cpu_op(1'b1, 1'b0, 8'h00, 8'h00, busy);
    check("cold miss busy cycles", 32'(busy), 32'd5);

    push(K_RD, 6'h00, 32'h000000DD);
    cpu_op(1'b1, 1'b0, 8'h03, 8'h00, busy);
    check("read hit busy cycles", 32'(busy), 32'd0);

    push(K_WR, 6'h00, 32'h0);
    cpu_op(1'b0, 1'b1, 8'h01, 8'h55, busy);
    check("write hit busy cycles", 32'(busy), 32'd0);
    push(K_RD, 6'h00, 32'h00000055);
    cpu_op(1'b1, 1'b0, 8'h01, 8'h00, busy);
    check("read after write busy cycles", 32'(busy), 32'd0);

    // Conflict miss on dirty line 0; hold the fetch and reset in the middle of it
    push(K_MWR, 6'h00, 32'hDDCC55AA);
    push(K_MRD, 6'h08, 32'h0);
    READ    = 1'b1;
    ADDRESS = 8'h20;
    seen    = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge CLK);
      if (mem_read) seen = 1'b1;
    end
    check("fetch reached", 32'(seen), 32'h1);
    mem_hold = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    check("fetch held mem_read", 32'(mem_read), 32'h1);
`ifdef DATA_CACHE_STATS_EN
    check("hit_count before reset", 32'(hit_count), 32'd3);
    check("miss_count before reset", 32'(miss_count), 32'd2);
`endif
    RESET = 1'b1;
    READ  = 1'b0;
    @(posedge CLK);
    #1;
    check("abort mem_read", 32'(mem_read), 32'h0);
    check("abort mem_write", 32'(mem_write), 32'h0);
    check("abort BUSYWAIT", 32'(BUSYWAIT), 32'h0);
`ifdef DATA_CACHE_STATS_EN
    check("hit_count after reset", 32'(hit_count), 32'd0);
    check("miss_count after reset", 32'(miss_count), 32'd0);
`endif
    RESET    = 1'b0;
    mem_hold = 1'b0;
    @(posedge CLK);
    #1;

    // Valid bits cleared: block 0 refetched, now carrying the written-back byte
    push(K_MRD, 6'h00, 32'h0);
    push(K_RD, 6'h00, 32'h000000AA);
    cpu_op(1'b1, 1'b0, 8'h00, 8'h00, busy);
    check("post-reset miss busy cycles", 32'(busy), 32'd5);
    push(K_RD, 6'h00, 32'h00000055);
    cpu_op(1'b1, 1'b0, 8'h01, 8'h00, busy);

    // READ and WRITE together behave as a write
    push(K_WR, 6'h00, 32'h0);
    cpu_op(1'b1, 1'b1, 8'h02, 8'h77, busy);
    push(K_RD, 6'h00, 32'h00000077);
    cpu_op(1'b1, 1'b0, 8'h02, 8'h00, busy);

    // Write miss on clean index 1 allocates block 9, then the byte is stored
    push(K_MRD, 6'h09, 32'h0);
    push(K_WR, 6'h00, 32'h0);
    cpu_op(1'b0, 1'b1, 8'h24, 8'h99, busy);
    check("write miss busy cycles", 32'(busy), 32'd5);
    push(K_RD, 6'h00, 32'h00000099);
    cpu_op(1'b1, 1'b0, 8'h24, 8'h00, busy);
    push(K_RD, 6'h00, 32'h00000000);
    cpu_op(1'b1, 1'b0, 8'h25, 8'h00, busy);

    repeat (3) @(posedge CLK);
    #1;
    check("scoreboard drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
